// File: rtl/rcc_cr_ctrl.sv
// Clock-source request sequencer: enables external 100M, selects it once ready is stable, falls back on timeout/loss.
// Registered outputs change one clk_sys edge after the triggering write or synced-ready event; no backpressure, writes always accepted.
module rcc_cr_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_data,
    input  logic       clk_ext_ready_in,
    output logic [1:0] rcc_cr_out,
    output logic       busy,
    output logic       src_ext,
    output logic       err_timeout,
    output logic       err_loss
);

    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam int SW = $clog2(STABLE_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, WAIT_RDY, STABLE, SEL_EXT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rdy_s;
    logic [TW-1:0]          tmo_cnt;
    logic [SW-1:0]          stab_cnt;
    logic                   req, abort, clr, tmo_exp, sel_go, set_tmo, set_loss;

    assign rdy_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], clk_ext_ready_in};
    end

    // A cancel write overrides every in-flight event, so it never raises an error flag.
    always_comb begin
        req      = wr_en & wr_data[0];
        abort    = wr_en & ~wr_data[0];
        clr      = wr_en & wr_data[1];
        tmo_exp  = (tmo_cnt >= TMO_LAST);
        sel_go   = (state == STABLE) && rdy_s && (stab_cnt == STAB_LAST);
        set_tmo  = !abort && (((state == WAIT_RDY) && !rdy_s && tmo_exp) ||
                              ((state == STABLE) && !sel_go && tmo_exp));
        set_loss = !abort && (state == SEL_EXT) && !rdy_s;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
            err_loss    <= 1'b0;
        end else begin
            err_timeout <= set_tmo  | (err_timeout & ~clr);
            err_loss    <= set_loss | (err_loss & ~clr);
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            stab_cnt   <= '0;
            rcc_cr_out <= 2'b00;
            busy       <= 1'b0;
            src_ext    <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            rcc_cr_out <= 2'b00;
            busy       <= 1'b0;
            src_ext    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state      <= WAIT_RDY;
                        tmo_cnt    <= '0;
                        stab_cnt   <= '0;
                        rcc_cr_out <= 2'b10;
                        busy       <= 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (set_tmo) begin
                        state      <= IDLE;
                        rcc_cr_out <= 2'b00;
                        busy       <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                        if (rdy_s) begin
                            state    <= STABLE;
                            stab_cnt <= SW'(1);
                        end
                    end
                end
                STABLE: begin
                    if (sel_go) begin
                        state      <= SEL_EXT;
                        rcc_cr_out <= 2'b01;
                        busy       <= 1'b0;
                        src_ext    <= 1'b1;
                    end else if (set_tmo) begin
                        state      <= IDLE;
                        rcc_cr_out <= 2'b00;
                        busy       <= 1'b0;
                    end else begin
                        // The timeout budget spans retries, so only the stability run restarts.
                        tmo_cnt <= tmo_cnt + TW'(1);
                        if (!rdy_s) begin
                            state    <= WAIT_RDY;
                            stab_cnt <= '0;
                        end else begin
                            stab_cnt <= stab_cnt + SW'(1);
                        end
                    end
                end
                SEL_EXT: begin
                    if (!rdy_s) begin
                        state      <= IDLE;
                        rcc_cr_out <= 2'b00;
                        src_ext    <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    rcc_cr_out <= 2'b00;
                    busy       <= 1'b0;
                    src_ext    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rcc_cr_ctrl.sv
// Bench for rcc_cr_ctrl: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_rcc_cr_ctrl;
    localparam int SYNC = 2;
    localparam int STAB = 16;
    localparam int TMO  = 4096;

    logic       clk_sys = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_data = 2'b00;
    logic       clk_ext_ready_in = 1'b0;
    logic [1:0] rcc_cr_out;
    logic       busy, src_ext, err_timeout, err_loss;

    int vectors = 0;
    int miscompares = 0;

    // Model: mode 0 = internal, 1 = sequencing, 2 = external selected
    int m_mode, m_elapsed, m_run;
    bit m_et, m_el;
    bit m_pipe[SYNC];

    rcc_cr_ctrl #(.SYNC_STAGES(SYNC), .STABLE_CYC(STAB), .TIMEOUT_CYC(TMO)) dut (
        .clk_sys(clk_sys), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .clk_ext_ready_in(clk_ext_ready_in), .rcc_cr_out(rcc_cr_out), .busy(busy),
        .src_ext(src_ext), .err_timeout(err_timeout), .err_loss(err_loss)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [5:0] obs_vec();
        return {rcc_cr_out, busy, src_ext, err_timeout, err_loss};
    endfunction

    function automatic logic [5:0] exp_vec();
        logic [3:0] o;
        case (m_mode)
            1:       o = 4'b10_1_0;
            2:       o = 4'b01_0_1;
            default: o = 4'b00_0_0;
        endcase
        return {o, m_et, m_el};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_elapsed = 0; m_run = 0; m_et = 0; m_el = 0;
        for (int i = 0; i < SYNC; i++) m_pipe[i] = 0;
    endtask

    task automatic model_edge();
        bit rdy, abort, req, clr, st, sl;
        rdy = m_pipe[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = clk_ext_ready_in;
        abort = wr_en && !wr_data[0];
        req   = wr_en && wr_data[0];
        clr   = wr_en && wr_data[1];
        st = 0; sl = 0;
        if (abort) m_mode = 0;
        else case (m_mode)
            0: if (req) begin m_mode = 1; m_elapsed = 0; m_run = 0; end
            1: begin
                m_elapsed++;
                if (rdy && m_run + 1 >= STAB) m_mode = 2;
                else if (m_elapsed >= TMO && !(m_run == 0 && rdy)) begin m_mode = 0; st = 1; end
                else m_run = rdy ? m_run + 1 : 0;
            end
            default: if (!rdy) begin m_mode = 0; sl = 1; end
        endcase
        m_et = st | (m_et & !clr);
        m_el = sl | (m_el & !clr);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        if (rst) model_reset(); else model_edge();
        #1;
    endtask

    task automatic wr(input logic [1:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0; wr_data = 2'b00;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        vectors++;
        if (obs_vec() !== 6'b000000) begin
            miscompares++; $display("FAIL reset_state: got %b want %b", obs_vec(), 6'b000000);
        end
        tick(); tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL reset_idle: got %b want %b", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_select();
        int n;
        clk_ext_ready_in = 1'b0;
        wr(2'b01);
        vectors++;
        if (obs_vec() !== 6'b10_1_0_00) begin
            miscompares++; $display("FAIL select_enable: got %b want %b", obs_vec(), 6'b10_1_0_00);
        end
        repeat (50) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL select_wait: got %b want %b", obs_vec(), exp_vec());
            end
        end
        clk_ext_ready_in = 1'b1;
        n = 0;
        while (n < 100 && rcc_cr_out !== 2'b01) begin
            tick(); n++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL select_stable: got %b want %b", obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (n !== SYNC + STAB || src_ext !== 1'b1) begin
            miscompares++; $display("FAIL select_latency: got %0d cyc src_ext=%b want %0d cyc src_ext=1", n, src_ext, SYNC + STAB);
        end
    endtask

    task automatic test_loss();
        int n;
        clk_ext_ready_in = 1'b0;
        n = 0;
        while (n < 20 && rcc_cr_out !== 2'b00) begin
            tick(); n++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL loss_seq: got %b want %b", obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (n !== SYNC + 1 || err_loss !== 1'b1 || src_ext !== 1'b0) begin
            miscompares++; $display("FAIL loss_fallback: got %0d cyc err_loss=%b want %0d cyc err_loss=1", n, err_loss, SYNC + 1);
        end
        wr(2'b10);
        vectors++;
        if (obs_vec() !== 6'b000000) begin
            miscompares++; $display("FAIL loss_clear: got %b want %b", obs_vec(), 6'b000000);
        end
    endtask

    task automatic test_timeout();
        int n;
        clk_ext_ready_in = 1'b0;
        wr(2'b01);
        n = 0;
        while (n < TMO + 100 && rcc_cr_out !== 2'b00) begin
            tick(); n++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL timeout_seq: got %b want %b", obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (n !== TMO || err_timeout !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL timeout_expiry: got %0d cyc err=%b busy=%b want %0d cyc err=1 busy=0", n, err_timeout, busy, TMO);
        end
        wr(2'b10);
        vectors++;
        if (err_timeout !== 1'b0) begin
            miscompares++; $display("FAIL timeout_clear: got %b want 0", err_timeout);
        end
    endtask

    task automatic test_glitch();
        int n;
        clk_ext_ready_in = 1'b0;
        wr(2'b01);
        repeat (3) tick();
        clk_ext_ready_in = 1'b1;
        repeat (5) tick();
        clk_ext_ready_in = 1'b0;
        repeat (25) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec() || rcc_cr_out !== 2'b10) begin
                miscompares++; $display("FAIL glitch_hold: got %b want %b", obs_vec(), exp_vec());
            end
        end
        clk_ext_ready_in = 1'b1;
        n = 0;
        while (n < 100 && rcc_cr_out !== 2'b01) begin
            tick(); n++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL glitch_retry: got %b want %b", obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (n !== SYNC + STAB) begin
            miscompares++; $display("FAIL glitch_latency: got %0d want %0d", n, SYNC + STAB);
        end
    endtask

    task automatic test_abort();
        clk_ext_ready_in = 1'b0;
        repeat (5) tick();
        wr(2'b01);
        repeat (20) begin
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL abort_wait: got %b want %b", obs_vec(), exp_vec());
            end
        end
        wr(2'b00);
        vectors++;
        if (obs_vec() !== 6'b000000) begin
            miscompares++; $display("FAIL abort_idle: got %b want %b", obs_vec(), 6'b000000);
        end
        wr(2'b01);
        vectors++;
        if (obs_vec() !== 6'b10_1_0_00) begin
            miscompares++; $display("FAIL abort_restart: got %b want %b", obs_vec(), 6'b10_1_0_00);
        end
    endtask

    task automatic test_async_reset();
        clk_ext_ready_in = 1'b1;
        repeat (SYNC + STAB + 4) tick();
        vectors++;
        if (rcc_cr_out !== 2'b01 || exp_vec() !== obs_vec()) begin
            miscompares++; $display("FAIL areset_pre: got %b want %b", obs_vec(), exp_vec());
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (obs_vec() !== 6'b000000) begin
            miscompares++; $display("FAIL areset_immediate: got %b want %b", obs_vec(), 6'b000000);
        end
        tick();
        rst = 1'b0;
        repeat (5) begin
            tick();
            vectors++;
            if (obs_vec() !== 6'b000000) begin
                miscompares++; $display("FAIL areset_idle: got %b want %b", obs_vec(), 6'b000000);
            end
        end
    endtask

    task automatic test_random();
        repeat (3000) begin
            if ($urandom_range(39) == 0) begin
                wr_en = 1'b1; wr_data = 2'($urandom_range(3));
            end else begin
                wr_en = 1'b0; wr_data = 2'b00;
            end
            if ($urandom_range(24) == 0) clk_ext_ready_in = ~clk_ext_ready_in;
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL random: got %b want %b", obs_vec(), exp_vec());
            end
        end
        wr_en = 1'b0; wr_data = 2'b00;
    endtask

    initial begin
        test_reset();
        test_select();
        test_loss();
        test_timeout();
        test_glitch();
        test_loss();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
